// File: rtl/req_ack_responder.sv
// req/ack responder: every sampled request is acknowledged LAT cycles later,
// with a small in-order backlog FIFO absorbing requests that mature under hold.
module req_ack_responder #(
  parameter int LAT   = 1,
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic [DW-1:0]          req_data,
  input  logic                   hold,
  input  logic                   clr,
  output logic                   ack,
  output logic [DW-1:0]          ack_data,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   overflow,
  output logic [1:0]             state
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_BACKLOG = 2'd2
  } state_e;

  if (LAT < 1 || LAT > 8) begin : g_bad_lat
    $error("LAT must be in 1..8");
  end
  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two in 2..16");
  end

  logic [LAT-1:0] vld_q;
  logic [LAT-1:0] vld_d;
  logic [DW-1:0]  dat_q [LAT];
  logic [DW-1:0]  dat_d [LAT];

  logic [DW-1:0]  mem_q [DEPTH];
  logic [AW-1:0]  wptr_q;
  logic [AW-1:0]  wptr_d;
  logic [AW-1:0]  rptr_q;
  logic [AW-1:0]  rptr_d;
  logic [PW-1:0]  cnt_q;
  logic [PW-1:0]  cnt_d;

  logic           ack_q;
  logic           ack_d;
  logic [DW-1:0]  ack_data_q;
  logic [DW-1:0]  ack_data_d;
  logic           ovf_q;
  logic           ovf_d;
  state_e         state_q;
  state_e         state_d;

  logic           mat_v;
  logic [DW-1:0]  mat_data;
  logic           empty;
  logic           full;
  logic           pop;
  logic           direct;
  logic           push_need;
  logic           push;
  logic           drop;

  always_comb begin
    vld_d    = '0;
    vld_d[0] = req;
    dat_d[0] = req_data;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign mat_v    = vld_q[LAT-1];
  assign mat_data = dat_q[LAT-1];

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == PW'(DEPTH));

  // The FIFO head always wins over the direct path so ordering holds.
  assign pop       = !hold && !empty;
  assign direct    = !hold && empty && mat_v;
  assign push_need = mat_v && !direct;
  assign push      = push_need && (!full || pop);
  assign drop      = push_need && full && !pop;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    ack_d      = 1'b0;
    ack_data_d = ack_data_q;
    unique case (1'b1)
      pop: begin
        ack_d      = 1'b1;
        ack_data_d = mem_q[rptr_q];
      end
      direct: begin
        ack_d      = 1'b1;
        ack_data_d = mat_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (clr) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  always_comb begin
    state_d = S_IDLE;
    if (cnt_d != '0) begin
      state_d = S_BACKLOG;
    end else if (|vld_d) begin
      state_d = S_BUSY;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= mat_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      ack_q      <= 1'b0;
      ack_data_q <= '0;
      ovf_q      <= 1'b0;
      state_q    <= S_IDLE;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      ack_data_q <= ack_data_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
    end
  end

  assign ack      = ack_q;
  assign ack_data = ack_data_q;
  assign pending  = cnt_q;
  assign overflow = ovf_q;
  assign state    = state_q;

endmodule

// File: tb/tb_req_ack_responder.sv
// Directed bench for req_ack_responder: vector table for LAT=1 flows plus
// hand sequences for async reset and LAT=3 latency.
module tb_req_ack_responder;

  logic       clk;
  logic       rst;
  logic       req;
  logic [7:0] req_data;
  logic       hold;
  logic       clr;

  logic       ack1;
  logic [7:0] ad1;
  logic [2:0] pend1;
  logic       ovf1;
  logic [1:0] st1;

  logic       ack3;
  logic [7:0] ad3;
  logic [2:0] pend3;
  logic       ovf3;
  logic [1:0] st3;

  int checks = 0;
  int errors = 0;

  req_ack_responder #(.LAT(1), .DEPTH(4), .DW(8)) u_l1 (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .hold     (hold),
    .clr      (clr),
    .ack      (ack1),
    .ack_data (ad1),
    .pending  (pend1),
    .overflow (ovf1),
    .state    (st1)
  );

  req_ack_responder #(.LAT(3), .DEPTH(4), .DW(8)) u_l3 (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .hold     (hold),
    .clr      (clr),
    .ack      (ack3),
    .ack_data (ad3),
    .pending  (pend3),
    .overflow (ovf3),
    .state    (st3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [7:0] d;
    logic       h;
    logic       c;
    logic       a;
    logic [7:0] ad;
    logic [2:0] p;
    logic       o;
    logic [1:0] s;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic [7:0] d,
                     input logic h, input logic c,
                     input logic a, input logic [7:0] ad,
                     input logic [2:0] p, input logic o,
                     input logic [1:0] s);
    vec_t v;
    v = '{r, d, h, c, a, ad, p, o, s};
    vq.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [7:0] d,
                       input logic h, input logic c);
    req      = r;
    req_data = d;
    hold     = h;
    clr      = c;
  endtask

  initial begin
    drive(0, 8'h00, 0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 0, ack1, 0);
    check("rst_data", 0, ad1, 0);
    check("rst_pend", 0, pend1, 0);
    check("rst_ovf", 0, ovf1, 0);
    check("rst_state", 0, st1, 0);
    check("rst_ack3", 0, ack3, 0);
    rst = 1'b0;

    // LAT=1 basic direct path
    add(1, 8'h11, 0, 0, 0, 8'h00, 0, 0, 1);
    add(1, 8'h22, 0, 0, 1, 8'h11, 0, 0, 1);
    add(0, 8'h00, 0, 0, 1, 8'h22, 0, 0, 0);
    add(1, 8'h44, 0, 0, 0, 8'h22, 0, 0, 1);
    add(0, 8'h00, 0, 0, 1, 8'h44, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 8'h44, 0, 0, 0);
    // hold for three cycles while requests keep coming
    add(1, 8'h00, 0, 0, 0, 8'h44, 0, 0, 1);
    add(1, 8'h01, 0, 0, 1, 8'h00, 0, 0, 1);
    add(1, 8'h02, 1, 0, 0, 8'h00, 1, 0, 2);
    add(1, 8'h03, 1, 0, 0, 8'h00, 2, 0, 2);
    add(1, 8'h04, 1, 0, 0, 8'h00, 3, 0, 2);
    add(1, 8'h05, 0, 0, 1, 8'h01, 3, 0, 2);
    add(0, 8'h00, 0, 0, 1, 8'h02, 3, 0, 2);
    add(0, 8'h00, 0, 0, 1, 8'h03, 2, 0, 2);
    add(0, 8'h00, 0, 0, 1, 8'h04, 1, 0, 2);
    add(0, 8'h00, 0, 0, 1, 8'h05, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 8'h05, 0, 0, 0);
    // overflow: six requests mature under hold, then clr
    add(1, 8'hA0, 1, 0, 0, 8'h05, 0, 0, 1);
    add(1, 8'hA1, 1, 0, 0, 8'h05, 1, 0, 2);
    add(1, 8'hA2, 1, 0, 0, 8'h05, 2, 0, 2);
    add(1, 8'hA3, 1, 0, 0, 8'h05, 3, 0, 2);
    add(1, 8'hA4, 1, 0, 0, 8'h05, 4, 0, 2);
    add(1, 8'hA5, 1, 0, 0, 8'h05, 4, 1, 2);
    add(0, 8'h00, 1, 0, 0, 8'h05, 4, 1, 2);
    add(0, 8'h00, 0, 0, 1, 8'hA0, 3, 1, 2);
    add(0, 8'h00, 0, 0, 1, 8'hA1, 2, 1, 2);
    add(0, 8'h00, 0, 0, 1, 8'hA2, 1, 1, 2);
    add(0, 8'h00, 0, 0, 1, 8'hA3, 0, 1, 0);
    add(0, 8'h00, 0, 1, 0, 8'hA3, 0, 0, 0);
    // full FIFO with simultaneous pop and push
    add(1, 8'hB0, 1, 0, 0, 8'hA3, 0, 0, 1);
    add(1, 8'hB1, 1, 0, 0, 8'hA3, 1, 0, 2);
    add(1, 8'hB2, 1, 0, 0, 8'hA3, 2, 0, 2);
    add(1, 8'hB3, 1, 0, 0, 8'hA3, 3, 0, 2);
    add(1, 8'hB4, 1, 0, 0, 8'hA3, 4, 0, 2);
    add(1, 8'hB5, 0, 0, 1, 8'hB0, 4, 0, 2);
    add(0, 8'h00, 0, 0, 1, 8'hB1, 4, 0, 2);
    add(0, 8'h00, 0, 0, 1, 8'hB2, 3, 0, 2);
    add(0, 8'h00, 0, 0, 1, 8'hB3, 2, 0, 2);
    add(0, 8'h00, 0, 0, 1, 8'hB4, 1, 0, 2);
    add(0, 8'h00, 0, 0, 1, 8'hB5, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 8'hB5, 0, 0, 0);

    foreach (vq[i]) begin
      drive(vq[i].r, vq[i].d, vq[i].h, vq[i].c);
      tick();
      check("ack", i, ack1, vq[i].a);
      check("ack_data", i, ad1, vq[i].ad);
      check("pending", i, pend1, vq[i].p);
      check("overflow", i, ovf1, vq[i].o);
      check("state", i, st1, vq[i].s);
    end

    // async reset in the middle of a backlog
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'hC0 + 8'(i), 1, 0);
      tick();
    end
    check("pre_rst_pend", 0, pend1, 3);
    check("pre_rst_state", 0, st1, 2);
    #2;
    rst = 1'b1;
    #1;
    check("arst_ack", 0, ack1, 0);
    check("arst_data", 0, ad1, 0);
    check("arst_pend", 0, pend1, 0);
    check("arst_ovf", 0, ovf1, 0);
    check("arst_state", 0, st1, 0);
    drive(0, 8'h00, 0, 0);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_ack", i, ack1, 0);
      check("post_rst_pend", i, pend1, 0);
    end
    drive(1, 8'hD7, 0, 0);
    tick();
    check("new_req_ack0", 0, ack1, 0);
    drive(0, 8'h00, 0, 0);
    tick();
    check("new_req_ack", 0, ack1, 1);
    check("new_req_data", 0, ad1, 8'hD7);
    tick();
    check("new_req_ack_end", 0, ack1, 0);

    // LAT=3 single request
    repeat (5) tick();
    drive(1, 8'hA5, 0, 0);
    tick();
    drive(0, 8'h00, 0, 0);
    tick();
    check("l3_ack_t1", 0, ack3, 0);
    check("l1_ack_t1", 0, ack1, 1);
    tick();
    check("l3_ack_t2", 0, ack3, 0);
    tick();
    check("l3_ack_t3", 0, ack3, 1);
    check("l3_data_t3", 0, ad3, 8'hA5);
    tick();
    check("l3_ack_t4", 0, ack3, 0);
    check("l3_pend", 0, pend3, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
